// File: rtl/icache_ctrl_pkg.sv
// Shared constants and FSM state type for the instruction-cache controller.
package icache_ctrl_pkg;

  localparam int ICACHE_LINES      = 64;
  localparam int ICACHE_LINE_BYTES = 16;
  localparam int OFF_W             = $clog2(ICACHE_LINE_BYTES);

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2,
    FLUSH  = 2'd3
  } icache_state_t;

endpackage

// File: rtl/icache_ctrl_if.sv
// Memory-side port of the instruction cache: one line read request, then four response beats.
// Request: a transfer happens in a cycle where mem_req_valid and mem_req_ready are both 1; addr is held until then.
// Response: each cycle with mem_resp_valid=1 carries one beat; there is no backpressure on responses.
interface icache_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, one line write, one valid-clear per cycle.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 32 - OFF_W - IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [127:0]     rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [127:0]     wr_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  // Only the valid bits are reset; tag/data contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, 4-beat line refill
// on a miss, and a line-by-line invalidate sweep for fence.i.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   core2icache_addr,
  input  logic          flush,
  output logic [127:0]  icache2core_data,
  output logic          icache2core_data_valid,
  icache_ctrl_if.master mem,
  output logic          busy,
  output icache_state_t dbg_state
);

  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 - OFF_W;

  icache_state_t    state, state_nxt;
  logic [LINE_W-1:0] miss_line;
  logic [1:0]        beat_cnt;
  logic [31:0]       refill_buf [4];
  logic [IDX_W-1:0]  flush_cnt;
  logic              flush_pending;

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [127:0]     arr_data;
  logic             hit;
  logic             last_beat;
  logic             flush_done;
  logic             wr_en;
  logic [127:0]     wr_data;

  wire unused_offset = &{1'b0, core2icache_addr[OFF_W-1:0]};

  assign fetch_idx  = core2icache_addr[OFF_W +: IDX_W];
  assign fetch_tag  = core2icache_addr[31 -: TAG_W];
  assign hit        = arr_valid && (arr_tag == fetch_tag);
  assign last_beat  = (state == REFILL) && mem.mem_resp_valid && (beat_cnt == 2'd3);
  assign flush_done = (state == FLUSH) && (flush_cnt == IDX_W'(LINES - 1));

  // The final beat goes straight into the array alongside the three buffered words.
  assign wr_en   = last_beat;
  assign wr_data = {mem.mem_resp_data, refill_buf[2], refill_buf[1], refill_buf[0]};

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (fetch_idx),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (wr_en),
    .wr_idx   (miss_line[IDX_W-1:0]),
    .wr_tag   (miss_line[LINE_W-1 -: TAG_W]),
    .wr_data  (wr_data),
    .clr_en   (state == FLUSH),
    .clr_idx  (flush_cnt)
  );

  assign icache2core_data       = arr_data;
  assign icache2core_data_valid = (state == LOOKUP) && hit;
  assign mem.mem_req_valid      = (state == REQ);
  assign mem.mem_req_addr       = {miss_line, {OFF_W{1'b0}}};
  assign busy                   = (state != LOOKUP);
  assign dbg_state              = state;

  always_comb begin
    state_nxt = state;
    case (state)
      LOOKUP: begin
        if (flush)     state_nxt = FLUSH;
        else if (!hit) state_nxt = REQ;
      end
      REQ: begin
        if (mem.mem_req_ready) state_nxt = REFILL;
      end
      REFILL: begin
        // A flush seen on the last beat itself still counts as pending.
        if (last_beat) state_nxt = (flush_pending || flush) ? FLUSH : LOOKUP;
      end
      FLUSH: begin
        if (flush_done) state_nxt = LOOKUP;
      end
      default: state_nxt = LOOKUP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LOOKUP;
      miss_line     <= '0;
      beat_cnt      <= 2'd0;
      flush_cnt     <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == LOOKUP) && !flush && !hit) miss_line <= core2icache_addr[31:OFF_W];

      if ((state == REQ) && mem.mem_req_ready)          beat_cnt <= 2'd0;
      else if ((state == REFILL) && mem.mem_resp_valid) beat_cnt <= beat_cnt + 2'd1;

      if (((state == REQ) || (state == REFILL)) && flush) flush_pending <= 1'b1;
      else if (flush_done)                               flush_pending <= 1'b0;

      if (state == FLUSH) flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if ((state == REFILL) && mem.mem_resp_valid) refill_buf[beat_cnt] <= mem.mem_resp_data;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: the bench plays the memory and checks against hand-computed lines.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic          flush;
  logic [127:0]  data;
  logic          data_valid;
  logic          busy;
  icache_state_t dbg_state;

  icache_ctrl_if mem ();

  icache_ctrl dut (
    .clock                  (clock),
    .reset                  (reset),
    .core2icache_addr       (addr),
    .flush                  (flush),
    .icache2core_data       (data),
    .icache2core_data_valid (data_valid),
    .mem                    (mem),
    .busy                   (busy),
    .dbg_state              (dbg_state)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  task automatic tick();
    @(posedge clock);
    #2;
    cycles++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the LOOKUP-miss cycle; leaves right after the edge that took the last beat.
  task automatic refill(input string tag, input logic [31:0] exp_addr, input logic [31:0] w0,
                        input int delay, input int gap, input int flush_beat,
                        input logic [31:0] switch_addr, input int switch_beat);
    tick();
    check({tag, ".req_valid"}, 128'(mem.mem_req_valid), 128'(1'b1));
    check({tag, ".req_addr"}, 128'(mem.mem_req_addr), 128'(exp_addr));
    check({tag, ".busy_req"}, 128'(busy), 128'(1'b1));
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, ".req_hold_valid"}, 128'(mem.mem_req_valid), 128'(1'b1));
      check({tag, ".req_hold_addr"}, 128'(mem.mem_req_addr), 128'(exp_addr));
    end
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    check({tag, ".state_refill"}, 128'(dbg_state), 128'(REFILL));
    check({tag, ".req_dropped"}, 128'(mem.mem_req_valid), 128'(1'b0));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) for (int g = 0; g < gap; g++) tick();
      if (b == switch_beat) addr = switch_addr;
      mem.mem_resp_valid = 1'b1;
      mem.mem_resp_data  = w0 + 32'(b);
      flush = (b == flush_beat);
      #1;
      check({tag, ".dv_refill"}, 128'(data_valid), 128'(1'b0));
      tick();
      mem.mem_resp_valid = 1'b0;
      mem.mem_resp_data  = 32'hFFFF_FFFF;
      flush = 1'b0;
    end
  endtask

  initial begin
    int c0;
    int n;
    logic dv_seen;

    reset = 1'b1;
    addr  = 32'h100;
    flush = 1'b0;
    mem.mem_req_ready  = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_resp_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    check("rst.state", 128'(dbg_state), 128'(LOOKUP));
    check("rst.busy", 128'(busy), 128'(1'b0));
    check("rst.req_valid", 128'(mem.mem_req_valid), 128'(1'b0));
    check("rst.data_valid", 128'(data_valid), 128'(1'b0));
    reset = 1'b0;

    // Cold miss at 0x100, memory ready at once, back-to-back beats.
    #1;
    check("t1.miss", 128'(data_valid), 128'(1'b0));
    c0 = cycles;
    refill("t1", 32'h100, 32'hA0, 0, 0, -1, 32'h0, -1);
    check("t1.latency", 128'(cycles - c0), 128'(6));
    check("t1.hit", 128'(data_valid), 128'(1'b1));
    check("t1.data", data, 128'h000000A3_000000A2_000000A1_000000A0);
    check("t1.busy", 128'(busy), 128'(1'b0));

    // Same line, different word offset.
    addr = 32'h104;
    #1;
    check("t2.hit", 128'(data_valid), 128'(1'b1));
    check("t2.data", data, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();
    check("t2.no_req", 128'(mem.mem_req_valid), 128'(1'b0));
    check("t2.state", 128'(dbg_state), 128'(LOOKUP));

    // Conflict miss on index 16, slow grant and gapped beats.
    addr = 32'h500;
    #1;
    check("t3.miss", 128'(data_valid), 128'(1'b0));
    refill("t3", 32'h500, 32'hB0, 5, 1, -1, 32'h0, -1);
    check("t3.hit", 128'(data_valid), 128'(1'b1));
    check("t3.data", data, 128'h000000B3_000000B2_000000B1_000000B0);

    // Stray response beat while idle.
    mem.mem_resp_valid = 1'b1;
    mem.mem_resp_data  = 32'hDEAD_BEEF;
    tick();
    mem.mem_resp_valid = 1'b0;
    check("stray.state", 128'(dbg_state), 128'(LOOKUP));
    check("stray.req", 128'(mem.mem_req_valid), 128'(1'b0));
    check("stray.data", data, 128'h000000B3_000000B2_000000B1_000000B0);

    // 0x100 was evicted; refill it with a flush pulse on beat 1.
    addr = 32'h100;
    #1;
    check("t4.evicted", 128'(data_valid), 128'(1'b0));
    refill("t4", 32'h100, 32'hC0, 0, 0, 1, 32'h0, -1);
    check("t4.state_flush", 128'(dbg_state), 128'(FLUSH));
    n = 1;
    dv_seen = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (n == 20) flush = 1'b1;
      if (data_valid) dv_seen = 1'b1;
      tick();
      flush = 1'b0;
      if (busy) n++;
    end
    check("t4.flush_len", 128'(n), 128'(64));
    check("t4.dv_in_flush", 128'(dv_seen), 128'(1'b0));
    check("t4.state_after", 128'(dbg_state), 128'(LOOKUP));
    check("t4.pending_clear", 128'(busy), 128'(1'b0));
    #1;
    check("t4.miss_again", 128'(data_valid), 128'(1'b0));

    // Address moves to 0x300 mid-refill of 0x200.
    addr = 32'h200;
    #1;
    check("t5.miss", 128'(data_valid), 128'(1'b0));
    refill("t5", 32'h200, 32'hD0, 0, 0, -1, 32'h300, 2);
    check("t5.no_stale_hit", 128'(data_valid), 128'(1'b0));
    check("t5.state", 128'(dbg_state), 128'(LOOKUP));
    refill("t6", 32'h300, 32'hE0, 0, 0, -1, 32'h0, -1);
    check("t6.hit", 128'(data_valid), 128'(1'b1));
    check("t6.data", data, 128'h000000E3_000000E2_000000E1_000000E0);
    addr = 32'h200;
    #1;
    check("t5.hit", 128'(data_valid), 128'(1'b1));
    check("t5.data", data, 128'h000000D3_000000D2_000000D1_000000D0);

    // Flush from LOOKUP, reset when the sweep reaches line 10.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t7.state_flush", 128'(dbg_state), 128'(FLUSH));
    check("t7.dv_flush", 128'(data_valid), 128'(1'b0));
    for (int i = 0; i < 10; i++) tick();
    check("t7.busy_mid", 128'(busy), 128'(1'b1));
    reset = 1'b1;
    tick();
    check("t7.rst_state", 128'(dbg_state), 128'(LOOKUP));
    check("t7.rst_busy", 128'(busy), 128'(1'b0));
    check("t7.rst_req", 128'(mem.mem_req_valid), 128'(1'b0));
    check("t7.rst_dv", 128'(data_valid), 128'(1'b0));
    reset = 1'b0;
    addr = 32'h100;
    #1;
    check("t7.miss", 128'(data_valid), 128'(1'b0));
    tick();
    check("t7.req_valid", 128'(mem.mem_req_valid), 128'(1'b1));
    check("t7.req_addr", 128'(mem.mem_req_addr), 128'(32'h100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller between the fetch stage and the memory port. It answers the fetch stage's line-aligned address with a 128-bit line (four instructions) on a hit in the same cycle. On a miss it sequences a 4-beat line refill from memory. It also sequences a full-cache invalidate for `fence.i`.

## Interface
Parameters:
- `LINES`, default 64: number of 16-byte lines; power of 2, ≥2.
- `IDX_W`, default `$clog2(LINES)`: index width.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `core2icache_addr` in 32: fetch address; bits [3:0] ignored.
- `flush` in 1: single-cycle pulse requesting invalidation of all lines.
- `icache2core_data` out 128: line data; word i occupies bits [32i+31:32i].
- `icache2core_data_valid` out 1: data is valid for the current `core2icache_addr`.
- `mem_req_valid` out 1: line read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: line-aligned request address, {tag, index, 4'b0}.
- `mem_resp_valid` in 1: one response beat is present.
- `mem_resp_data` in 32: response beat; beats arrive in ascending word order.
- `busy` out 1: state is not LOOKUP.

## Operation
- Address fields: index = addr[4+IDX_W-1:4]; tag = addr[31:4+IDX_W].
- Hit means valid[index] and tag[index] == addr tag.
- FSM states:
  - LOOKUP:
    - Hit: `data_valid`=1 and data = line[index], combinationally.
    - Miss: latch the line address into `miss_addr` and go to REQ.
    - `flush` in LOOKUP wins over a miss in the same cycle: go to FLUSH.
  - REQ:
    - Hold `mem_req_valid`=1 and `mem_req_addr`=`miss_addr` until `mem_req_ready`.
    - The handshake cycle goes to REFILL with beat counter = 0.
  - REFILL:
    - Each `mem_resp_valid` writes `mem_resp_data` into buffer word [counter], then counter increments.
    - Gaps between beats are legal.
    - On beat 3: write buffer plus the final beat to line[miss index], write the tag, set valid.
    - After beat 3: go to FLUSH if `flush_pending`, else to LOOKUP.
  - FLUSH:
    - Clear valid[cnt] with cnt counting 0..LINES-1, one line per cycle.
    - After clearing line LINES-1: clear `flush_pending` and go to LOOKUP.
- `flush` arriving in REQ or REFILL sets `flush_pending`; the refill is not aborted.
- `flush` arriving during FLUSH is absorbed, with no restart.
- The fetch address may change during REQ/REFILL. The refill still completes for `miss_addr`. LOOKUP then re-evaluates the current address.
- `icache2core_data_valid` is 0 in every state except LOOKUP-hit.
- `icache2core_data` is don't-care when valid is 0; the implementation drives line[index].
- The memory interface is never re-requested mid-refill. Stray `mem_resp_valid` outside REFILL is ignored.

## Timing
- Reset values:
  - state LOOKUP; all valid bits 0.
  - `mem_req_valid` 0, `icache2core_data_valid` 0, `busy` 0.
  - counters 0, `flush_pending` 0.
- Tag and data contents are not reset.
- Hit latency: 0 cycles, combinational from address.
- Miss, cycle by cycle:
  - Cycle M: LOOKUP-miss.
  - Cycle M+1: REQ.
  - Handshake cycle H: REFILL begins at H+1.
  - Last beat accepted at cycle B: LOOKUP at B+1, where the same address hits.
- With memory ready immediately and back-to-back beats: miss to hit is 6 cycles.
- Flush takes exactly LINES cycles in FLUSH, then LOOKUP.
- Reset mid-refill or mid-flush:
  - Returns to LOOKUP next cycle with all lines invalid.
  - The external memory must be reset together with the core.

## Structure
- In the shared common header: `ICACHE_LINES`, `ICACHE_LINE_BYTES` (16), and the `icache_state_t` enum {LOOKUP, REQ, REFILL, FLUSH}.
- Sub-module `icache_array`:
  - Holds the tag, valid, and data flop arrays.
  - Combinational read port, one write port, valid-clear port, synchronous reset of valid bits.
- `icache_ctrl` holds the FSM, `miss_addr`, the beat counter, the refill buffer, the flush counter, and `flush_pending`.

## Test plan
- After reset, addr 0x100 with memory returning beats 0xA0..0xA3 (ready immediately) → `mem_req_addr`=0x100. 6 cycles later `data_valid`=1 and data = {0xA3,0xA2,0xA1,0xA0}.
- Second access at 0x104 → hit with the same line and no memory request. Access at 0x100+16·LINES → miss that evicts index 16 (0x100 with LINES=64) and returns the new tag's data.
- `mem_req_ready` held low 5 cycles, then 1-cycle gaps between beats → request stays stable and words land in ascending order. A stray `mem_resp_valid` in LOOKUP changes nothing.
- `flush` pulsed during REFILL beat 1 → refill completes. Then FLUSH for LINES cycles with `busy`=1. Then 0x100 misses again.
- Fetch address switched from 0x200 to 0x300 during REFILL → 0x200 line installed, then 0x300 miss starts. `data_valid` is never 1 with 0x200 data while the address is 0x300.
- Reset asserted mid-FLUSH at cnt=10 → next cycle LOOKUP, all outputs at reset values, 0x100 misses.
